spatial_encoder_param: RTL and testbench
========================================

# spatial_encoder_param

Parametrised three-modality spatial encoder for the HD sensor-fusion pipeline. It sits between the input sample buffer and the temporal encoder. It walks the channels of each modality against item-memory (iM) and projection-memory SRAM banks, binds each channel, and bundles each modality by per-bit majority with a deterministic tie-break. It emits one hypervector per modality plus an optional fused 3-way majority. Channel counts, widths and fusion are parameters.

## Interface
- `HV_DIMENSION`, 2000: hypervector width.
- `CHANNEL_WIDTH`, 8: signed feature width.
- `MOD1_CHANNELS`, 32: channels in modality 1; must be ≥1.
- `MOD2_CHANNELS`, 77: channels in modality 2; must be ≥1.
- `MOD3_CHANNELS`, 105: channels in modality 3; must be ≥1.
- `ADDR_WIDTH`, 8: SRAM address width; 2^ADDR_WIDTH ≥ MAX_CH, where MAX_CH = max of the three channel counts.
- `FUSE_EN`, 1: 1 drives the fused output; 0 ties it to zero.
- `Clk_CI` in 1: clock.
- `Reset_RI` in 1: reset, asynchronous, active-high.
- `ValidIn_SI` in 1: input sample valid.
- `ReadyOut_SO` out 1: ready to accept a sample.
- `ChannelsInput_DI` in CHANNEL_WIDTH*(M1+M2+M3): channel c at bits [c*CHANNEL_WIDTH +: CHANNEL_WIDTH].
  - Modality 1 occupies channels 0..M1-1, modality 2 the next M2 channels, modality 3 the rest.
- `ValidOut_SO` out 1: result valid.
- `ReadyIn_SI` in 1: downstream ready.
- `HypervectorOut_mK_DO` out HV_DIMENSION (K=1..3): bundled hypervector of modality K.
- `HypervectorOut_DO` out HV_DIMENSION: fused majority of the three.
- `sram_addr` out ADDR_WIDTH: current channel index within each modality; shared by all banks.
- `sram_ready_mK` out 1: modality K requests data at `sram_addr`.
- `sram_valid_mK` in 1: iM/projection data for modality K is valid.
- `IM_mK_DI`, `ProjNeg_mK_DI`, `ProjPos_mK_DI` in HV_DIMENSION: SRAM read data for modality K.

## Operation
- **States:** IDLE, ACCUM, FINAL, DONE. Reset state is IDLE.
- **IDLE:**
  - `ReadyOut_SO` = 1.
  - On `ValidIn_SI`: latch every channel, clear the channel counter, clear all vote counters and tie registers, go to ACCUM.
- **ACCUM:**
  - Modality K is active while counter < MODK_CHANNELS.
  - `sram_ready_mK` = active_K.
  - Advance condition: for every active K, `sram_valid_mK` = 1. Inactive modalities ignore their valid.
  - On advance, for each active K:
    - feature f = latched channel (modality K base + counter).
    - bound = `IM_mK_DI` XOR (f < 0 ? `ProjNeg_mK_DI` : `ProjPos_mK_DI`), where f < 0 is the MSB of the signed feature.
    - Each per-bit vote counter adds its bound bit.
  - Tie-break, for modality K with even N = MODK_CHANNELS:
    - At counter 0, register bound0.
    - At counter 1, add one extra vote per bit equal to bound0 XOR bound1.
  - Counter increments on each advance; no advance means everything holds.
  - When counter = MAX_CH-1 and advancing, go to FINAL.
- **FINAL:** register the outputs, go to DONE.
  - Odd N: output bit = count ≥ (N+1)/2.
  - Even N: output bit = count ≥ (N+2)/2 (N+1 votes in total).
  - Fused bit = maj(m1, m2, m3) if FUSE_EN, else 0.
- **DONE:**
  - `ValidOut_SO` = 1.
  - Outputs are held stable until `ReadyIn_SI`, then go to IDLE.
- **Width rules:**
  - Vote counters are clog2(N+2) bits; they never overflow.
  - Counter compares are unsigned.
- `ChannelsInput_DI` and `ValidIn_SI` are ignored outside IDLE.

## Timing
- **Reset (async):**
  - State = IDLE, counter = 0, vote counters = 0.
  - All hypervector outputs = 0; `ValidOut_SO` = 0; `sram_ready_mK` = 0; `sram_addr` = 0.
  - `ReadyOut_SO` = 1 (IDLE decode).
- Reset mid-operation aborts the sample with no output.
- **Latency:** with the sample accepted in cycle t and no stalls:
  - ACCUM occupies t+1 .. t+MAX_CH.
  - FINAL occurs at t+MAX_CH+1.
  - `ValidOut_SO` rises at t+MAX_CH+2.
- Each stall cycle adds one cycle.
- **Handshake:**
  - An input transfer is `ValidIn_SI` & `ReadyOut_SO`.
  - An output transfer is `ValidOut_SO` & `ReadyIn_SI`.
  - The earliest next accept is the cycle after the output transfer; there is no same-cycle turnaround.
- `sram_addr` equals the counter combinationally. SRAM data is sampled on the same edge on which advance is true.
- `ReadyOut_SO`, `ValidOut_SO` and `sram_ready_mK` are decoded from registered state.

## Test plan
- M1=M2=M3=3, HV=8, all `sram_valid` high, iM=0xFF, ProjPos=0x0F, features +1,+1,-1 with ProjNeg=0xF0 → per-modality out = 0xF0, fused = 0xF0, `ValidOut_SO` at t+5.
- Even N=2, bound0=0xAA, bound1=0x55 → tie vote = 0xFF, out = 0xFF; with bound1=0xAA → out = 0xAA.
- Unequal counts 2/5/3: hold `sram_valid_m1` low at counter 3 → no stall (m1 inactive); hold `sram_valid_m3` low at counter 2 for 4 cycles → `ValidOut_SO` delayed exactly 4 cycles, result unchanged.
- Output backpressure:
  - Hold `ReadyIn_SI` low for 10 cycles in DONE → outputs stable, `ReadyOut_SO` = 0, a new `ValidIn_SI` is ignored.
  - Raise `ReadyIn_SI` → IDLE next cycle, and the next sample is accepted the cycle after.
- Assert `Reset_RI` mid-ACCUM, asynchronously between edges → outputs 0 and `ReadyOut_SO` = 1 immediately; the next sample produces a result identical to a clean run.
- FUSE_EN=0 → `HypervectorOut_DO` = 0 for all stimuli; per-modality outputs unchanged.

Source files
------------

// File: rtl/spatial_encoder_param.sv
// Three-modality HD spatial encoder: binds each channel against iM/projection SRAM data
// and bundles every modality by per-bit majority, with an optional fused 3-way majority.

module spatial_encoder_bundle #(
  parameter int HV_DIMENSION = 2000,
  parameter int NUM_CH       = 32,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    clr,
  input  logic                    adv,
  input  logic [ADDR_WIDTH-1:0]   cnt,
  input  logic [NUM_CH-1:0]       sgn,
  input  logic [HV_DIMENSION-1:0] im,
  input  logic [HV_DIMENSION-1:0] proj_neg,
  input  logic [HV_DIMENSION-1:0] proj_pos,
  output logic [HV_DIMENSION-1:0] bund
);
  localparam int VW   = $clog2(NUM_CH + 2);
  localparam bit EVEN = (NUM_CH % 2) == 0;
  // Even channel counts get one extra tie vote, so the threshold moves up by one.
  localparam int TH   = EVEN ? (NUM_CH + 2) / 2 : (NUM_CH + 1) / 2;

  logic                              f_neg;
  logic [HV_DIMENSION-1:0]           bound, tie, b0_q;
  logic [HV_DIMENSION-1:0][VW-1:0]   votes_q;

  always_comb begin
    f_neg = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (cnt == ADDR_WIDTH'(i)) f_neg = sgn[i];
  end

  assign bound = im ^ (f_neg ? proj_neg : proj_pos);
  assign tie   = (EVEN && cnt == ADDR_WIDTH'(1)) ? (b0_q ^ bound) : '0;

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      votes_q <= '0;
      b0_q    <= '0;
    end else if (clr) begin
      votes_q <= '0;
      b0_q    <= '0;
    end else if (adv) begin
      for (int i = 0; i < HV_DIMENSION; i++)
        votes_q[i] <= votes_q[i] + VW'(bound[i]) + VW'(tie[i]);
      if (cnt == '0) b0_q <= bound;
    end
  end

  always_comb begin
    bund = '0;
    for (int i = 0; i < HV_DIMENSION; i++) bund[i] = (votes_q[i] >= VW'(TH));
  end
endmodule

module spatial_encoder_param #(
  parameter int HV_DIMENSION  = 2000,
  parameter int CHANNEL_WIDTH = 8,
  parameter int MOD1_CHANNELS = 32,
  parameter int MOD2_CHANNELS = 77,
  parameter int MOD3_CHANNELS = 105,
  parameter int ADDR_WIDTH    = 8,
  parameter int FUSE_EN       = 1
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [CHANNEL_WIDTH*(MOD1_CHANNELS+MOD2_CHANNELS+MOD3_CHANNELS)-1:0] ChannelsInput_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [HV_DIMENSION-1:0] HypervectorOut_m1_DO,
  output logic [HV_DIMENSION-1:0] HypervectorOut_m2_DO,
  output logic [HV_DIMENSION-1:0] HypervectorOut_m3_DO,
  output logic [HV_DIMENSION-1:0] HypervectorOut_DO,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic                    sram_ready_m1,
  output logic                    sram_ready_m2,
  output logic                    sram_ready_m3,
  input  logic                    sram_valid_m1,
  input  logic                    sram_valid_m2,
  input  logic                    sram_valid_m3,
  input  logic [HV_DIMENSION-1:0] IM_m1_DI,
  input  logic [HV_DIMENSION-1:0] ProjNeg_m1_DI,
  input  logic [HV_DIMENSION-1:0] ProjPos_m1_DI,
  input  logic [HV_DIMENSION-1:0] IM_m2_DI,
  input  logic [HV_DIMENSION-1:0] ProjNeg_m2_DI,
  input  logic [HV_DIMENSION-1:0] ProjPos_m2_DI,
  input  logic [HV_DIMENSION-1:0] IM_m3_DI,
  input  logic [HV_DIMENSION-1:0] ProjNeg_m3_DI,
  input  logic [HV_DIMENSION-1:0] ProjPos_m3_DI
);
  localparam int TOT    = MOD1_CHANNELS + MOD2_CHANNELS + MOD3_CHANNELS;
  localparam int MAX12  = (MOD1_CHANNELS > MOD2_CHANNELS) ? MOD1_CHANNELS : MOD2_CHANNELS;
  localparam int MAX_CH = (MAX12 > MOD3_CHANNELS) ? MAX12 : MOD3_CHANNELS;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MAX_CH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

  state_t                           state_q;
  logic [ADDR_WIDTH-1:0]            cnt_q;
  logic [TOT-1:0]                   sgn_in, sgn_q;
  logic [2:0]                       act, vld;
  logic                             adv, clr;
  logic [2:0][HV_DIMENSION-1:0]     im_a, pn_a, pp_a, bund_a, hv_q;
  logic [HV_DIMENSION-1:0]          maj, fuse_q;

  // Only the feature sign selects the projection, so only signs are latched.
  always_comb begin
    sgn_in = '0;
    for (int c = 0; c < TOT; c++) sgn_in[c] = ChannelsInput_DI[c*CHANNEL_WIDTH + CHANNEL_WIDTH - 1];
  end

  assign im_a = {IM_m3_DI, IM_m2_DI, IM_m1_DI};
  assign pn_a = {ProjNeg_m3_DI, ProjNeg_m2_DI, ProjNeg_m1_DI};
  assign pp_a = {ProjPos_m3_DI, ProjPos_m2_DI, ProjPos_m1_DI};
  assign vld  = {sram_valid_m3, sram_valid_m2, sram_valid_m1};

  assign adv = (state_q == ACCUM) && (&(vld | ~act));
  assign clr = (state_q == IDLE) && ValidIn_SI;

  for (genvar k = 0; k < 3; k++) begin : g_mod
    localparam int NK   = (k == 0) ? MOD1_CHANNELS : (k == 1) ? MOD2_CHANNELS : MOD3_CHANNELS;
    localparam int BASE = (k == 0) ? 0 : (k == 1) ? MOD1_CHANNELS : MOD1_CHANNELS + MOD2_CHANNELS;
    localparam logic [ADDR_WIDTH:0] NLIM = (ADDR_WIDTH+1)'(NK);

    assign act[k] = (state_q == ACCUM) && ({1'b0, cnt_q} < NLIM);

    spatial_encoder_bundle #(
      .HV_DIMENSION(HV_DIMENSION), .NUM_CH(NK), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bundle (
      .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .clr(clr), .adv(adv && act[k]),
      .cnt(cnt_q), .sgn(sgn_q[BASE +: NK]),
      .im(im_a[k]), .proj_neg(pn_a[k]), .proj_pos(pp_a[k]), .bund(bund_a[k])
    );
  end

  assign maj = (bund_a[0] & bund_a[1]) | (bund_a[0] & bund_a[2]) | (bund_a[1] & bund_a[2]);

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sgn_q   <= '0;
      hv_q    <= '0;
      fuse_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (ValidIn_SI) begin
          sgn_q   <= sgn_in;
          cnt_q   <= '0;
          state_q <= ACCUM;
        end
        ACCUM: if (adv) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FINAL;
        end
        FINAL: begin
          hv_q    <= bund_a;
          fuse_q  <= (FUSE_EN != 0) ? maj : '0;
          state_q <= DONE;
        end
        DONE: if (ReadyIn_SI) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ReadyOut_SO          = (state_q == IDLE);
  assign ValidOut_SO          = (state_q == DONE);
  assign sram_addr            = cnt_q;
  assign sram_ready_m1        = act[0];
  assign sram_ready_m2        = act[1];
  assign sram_ready_m3        = act[2];
  assign HypervectorOut_m1_DO = hv_q[0];
  assign HypervectorOut_m2_DO = hv_q[1];
  assign HypervectorOut_m3_DO = hv_q[2];
  assign HypervectorOut_DO    = fuse_q;
endmodule

// File: tb/tb_spatial_encoder_param.sv
// Scoreboard bench: instance A (2/5/3 channels, fused) and instance B (3/3/3, fusion off).

module tb_spatial_encoder_param;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: M1=2, M2=5, M3=3, HV=8, MAX_CH=5
  logic        vin = 1'b0, rin = 1'b0, rdy_out, vout;
  logic [79:0] ch = '0;
  logic [7:0]  h1, h2, h3, hf;
  logic [2:0]  addr, sr, sv = 3'b111;
  logic [7:0]  tim [3][8];
  logic [7:0]  tpn [3][8];
  logic [7:0]  tpp [3][8];
  logic [7:0]  feat [10];

  // Instance B: M1=M2=M3=3, fusion disabled, MAX_CH=3
  logic        bvin = 1'b0, brin = 1'b0, brdy, bvout;
  logic [71:0] bch = '0;
  logic [7:0]  bh1, bh2, bh3, bhf;
  logic [1:0]  baddr;
  logic [2:0]  bsr;

  int vecs = 0, errs = 0;

  typedef struct packed { logic [7:0] h1, h2, h3, f; } exp_t;
  exp_t sb[$];

  spatial_encoder_param #(
    .HV_DIMENSION(8), .CHANNEL_WIDTH(8), .MOD1_CHANNELS(2), .MOD2_CHANNELS(5),
    .MOD3_CHANNELS(3), .ADDR_WIDTH(3), .FUSE_EN(1)
  ) dut_a (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin), .ReadyOut_SO(rdy_out),
    .ChannelsInput_DI(ch), .ValidOut_SO(vout), .ReadyIn_SI(rin),
    .HypervectorOut_m1_DO(h1), .HypervectorOut_m2_DO(h2), .HypervectorOut_m3_DO(h3),
    .HypervectorOut_DO(hf), .sram_addr(addr),
    .sram_ready_m1(sr[0]), .sram_ready_m2(sr[1]), .sram_ready_m3(sr[2]),
    .sram_valid_m1(sv[0]), .sram_valid_m2(sv[1]), .sram_valid_m3(sv[2]),
    .IM_m1_DI(tim[0][addr]), .ProjNeg_m1_DI(tpn[0][addr]), .ProjPos_m1_DI(tpp[0][addr]),
    .IM_m2_DI(tim[1][addr]), .ProjNeg_m2_DI(tpn[1][addr]), .ProjPos_m2_DI(tpp[1][addr]),
    .IM_m3_DI(tim[2][addr]), .ProjNeg_m3_DI(tpn[2][addr]), .ProjPos_m3_DI(tpp[2][addr])
  );

  spatial_encoder_param #(
    .HV_DIMENSION(8), .CHANNEL_WIDTH(8), .MOD1_CHANNELS(3), .MOD2_CHANNELS(3),
    .MOD3_CHANNELS(3), .ADDR_WIDTH(2), .FUSE_EN(0)
  ) dut_b (
    .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(bvin), .ReadyOut_SO(brdy),
    .ChannelsInput_DI(bch), .ValidOut_SO(bvout), .ReadyIn_SI(brin),
    .HypervectorOut_m1_DO(bh1), .HypervectorOut_m2_DO(bh2), .HypervectorOut_m3_DO(bh3),
    .HypervectorOut_DO(bhf), .sram_addr(baddr),
    .sram_ready_m1(bsr[0]), .sram_ready_m2(bsr[1]), .sram_ready_m3(bsr[2]),
    .sram_valid_m1(1'b1), .sram_valid_m2(1'b1), .sram_valid_m3(1'b1),
    .IM_m1_DI(8'hFF), .ProjNeg_m1_DI(8'hF0), .ProjPos_m1_DI(8'h0F),
    .IM_m2_DI(8'hFF), .ProjNeg_m2_DI(8'hF0), .ProjPos_m2_DI(8'h0F),
    .IM_m3_DI(8'hFF), .ProjNeg_m3_DI(8'hF0), .ProjPos_m3_DI(8'h0F)
  );

  // Reference bundler for instance A: bind, count, even-N tie vote, threshold.
  function automatic logic [7:0] model(input int k);
    int n, base, v;
    logic [7:0] bd [5];
    logic [7:0] r;
    n    = (k == 0) ? 2 : (k == 1) ? 5 : 3;
    base = (k == 0) ? 0 : (k == 1) ? 2 : 7;
    for (int c = 0; c < n; c++)
      bd[c] = tim[k][c] ^ (feat[base+c][7] ? tpn[k][c] : tpp[k][c]);
    r = '0;
    for (int j = 0; j < 8; j++) begin
      v = 0;
      for (int c = 0; c < n; c++) v += int'(bd[c][j]);
      if (n % 2 == 0) begin
        v += int'(bd[0][j] ^ bd[1][j]);
        r[j] = (v >= (n + 2) / 2);
      end else begin
        r[j] = (v >= (n + 1) / 2);
      end
    end
    return r;
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 8; a++) begin
        tim[k][a] = 8'($urandom);
        tpn[k][a] = 8'($urandom);
        tpp[k][a] = 8'($urandom);
      end
    for (int c = 0; c < 10; c++) feat[c] = 8'($urandom);
  endtask

  // Drives one sample through A; optional stall of modality sk at counter sat for slen cycles,
  // and hold cycles of downstream backpressure with a spurious ValidIn.
  task automatic run_sample(input int sk, input int sat, input int slen, input int hold, input int exp_lat);
    exp_t e;
    int n, rem;
    e.h1 = model(0); e.h2 = model(1); e.h3 = model(2);
    e.f  = (e.h1 & e.h2) | (e.h1 & e.h3) | (e.h2 & e.h3);
    sb.push_back(e);
    n = 0;
    while (!rdy_out && n < 50) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) ch[c*8 +: 8] = feat[c];
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    rem = slen; n = 0;
    while (!vout && n < 100) begin
      sv = 3'b111;
      if (sk >= 0 && rem > 0 && int'(addr) == sat) begin
        sv[sk] = 1'b0;
        if (sr[sk]) rem--;
      end
      @(posedge clk); #1; n++;
    end
    sv = 3'b111;
    vecs++;
    if (n !== exp_lat) begin errs++; $display("FAIL latency: got %0d cycles, want %0d", n, exp_lat); end
    e = sb.pop_front();
    vecs++;
    if ({h1, h2, h3, hf} !== {e.h1, e.h2, e.h3, e.f}) begin
      errs++;
      $display("FAIL result: got m1=%h m2=%h m3=%h fused=%h, want %h %h %h %h", h1, h2, h3, hf, e.h1, e.h2, e.h3, e.f);
    end
    for (int i = 0; i < hold; i++) begin
      vin = 1'b1;
      @(posedge clk); #1;
      vecs++;
      if ({vout, rdy_out, h1, h2, h3, hf} !== {1'b1, 1'b0, e.h1, e.h2, e.h3, e.f}) begin
        errs++;
        $display("FAIL backpressure: got vout=%b rdy=%b out=%h%h%h%h", vout, rdy_out, h1, h2, h3, hf);
      end
    end
    vin = 1'b0;
    rin = 1'b1;
    @(posedge clk); #1;
    rin = 1'b0;
    vecs++;
    if ({vout, rdy_out} !== 2'b01) begin
      errs++; $display("FAIL release: got vout=%b rdy=%b, want vout=0 rdy=1", vout, rdy_out);
    end
  endtask

  task automatic test_reset();
    #12;
    vecs++;
    if ({rdy_out, vout, sr, addr, h1, h2, h3, hf} !== {1'b1, 1'b0, 3'b000, 3'b000, 32'h0}) begin
      errs++; $display("FAIL reset_a: rdy=%b vout=%b sr=%b addr=%0d out=%h%h%h%h", rdy_out, vout, sr, addr, h1, h2, h3, hf);
    end
    vecs++;
    if ({brdy, bvout, bsr, baddr, bh1, bh2, bh3, bhf} !== {1'b1, 1'b0, 3'b000, 2'b00, 32'h0}) begin
      errs++; $display("FAIL reset_b: rdy=%b vout=%b sr=%b addr=%0d", brdy, bvout, bsr, baddr);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_tie_break();
    fill_rand();
    tim[0][0] = 8'h00; tpp[0][0] = 8'hAA; tpn[0][0] = 8'hAA;
    tim[0][1] = 8'h00; tpp[0][1] = 8'h55; tpn[0][1] = 8'h55;
    run_sample(-1, 0, 0, 0, 6);
    vecs++;
    if (h1 !== 8'hFF) begin errs++; $display("FAIL tie_split: got %h, want ff", h1); end
    tpp[0][1] = 8'hAA; tpn[0][1] = 8'hAA;
    run_sample(-1, 0, 0, 0, 6);
    vecs++;
    if (h1 !== 8'hAA) begin errs++; $display("FAIL tie_agree: got %h, want aa", h1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      fill_rand();
      run_sample(-1, 0, 0, 0, 6);
    end
  endtask

  task automatic test_stall();
    fill_rand();
    run_sample(0, 3, 3, 0, 6);   // m1 is done at counter 3, its valid is ignored
    run_sample(2, 2, 4, 0, 10);  // m3 withholds data four cycles
  endtask

  task automatic test_backpressure();
    fill_rand();
    run_sample(-1, 0, 0, 10, 6);
    run_sample(-1, 0, 0, 0, 6);
  endtask

  task automatic test_reset_mid();
    fill_rand();
    for (int c = 0; c < 10; c++) ch[c*8 +: 8] = feat[c];
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    vecs++;
    if ({rdy_out, vout, sr, h1, h2, h3, hf} !== {1'b1, 1'b0, 3'b000, 32'h0}) begin
      errs++; $display("FAIL reset_mid: rdy=%b vout=%b sr=%b out=%h%h%h%h", rdy_out, vout, sr, h1, h2, h3, hf);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_sample(-1, 0, 0, 0, 6);
  endtask

  task automatic b_sample(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2, input logic [7:0] exp_hv);
    int n;
    for (int m = 0; m < 3; m++) begin
      bch[(m*3+0)*8 +: 8] = f0;
      bch[(m*3+1)*8 +: 8] = f1;
      bch[(m*3+2)*8 +: 8] = f2;
    end
    bvin = 1'b1;
    @(posedge clk); #1;
    bvin = 1'b0;
    n = 0;
    while (!bvout && n < 50) begin @(posedge clk); #1; n++; end
    vecs++;
    if (n !== 4) begin errs++; $display("FAIL b_latency: got %0d, want 4", n); end
    vecs++;
    if ({bh1, bh2, bh3, bhf} !== {exp_hv, exp_hv, exp_hv, 8'h00}) begin
      errs++; $display("FAIL b_result: got %h %h %h fused=%h, want %h x3 fused=00", bh1, bh2, bh3, bhf, exp_hv);
    end
    brin = 1'b1;
    @(posedge clk); #1;
    brin = 1'b0;
  endtask

  task automatic test_fuse_off();
    b_sample(8'h01, 8'h01, 8'hFF, 8'hF0);
    b_sample(8'hFF, 8'h80, 8'h01, 8'h0F);
  endtask

  initial begin
    test_reset();
    test_tie_break();
    test_random();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_fuse_off();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
